// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg
// ----------------------------------------------------------------------------
// Definitions shared by the serial-pattern path. This covers the pattern
// transmitter (seq_generator), its shifter (seq_shifter), and the 101
// sequence detector that consumes the transmitter's X output.
//
// Contents:
//   REPS_W       width of the repetition count field
//   seq_state_t  2-bit state encoding (IDLE=00, SEND=01, PAR=10, DONE=11)
//   eff_len()    maps a requested pattern length onto the length actually
//                sent (0 or anything above the pattern width means "full")
//
// Configuration macro: SEQGEN_PARITY_EN (see seq_generator.sv). PAR is only
// reachable when that macro is defined, but the encoding is fixed either way
// so that both builds name the states identically.
// ============================================================================
package seq_pkg;

    localparam int REPS_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        PAR  = 2'b10,
        DONE = 2'b11
    } seq_state_t;

    // A zero length, or one longer than the pattern register, selects the
    // whole register. Senders can therefore pass 0 to mean "all bits".
    function automatic int eff_len(input int len_req, input int width);
        if (len_req == 0 || len_req > width) begin
            return width;
        end
        return len_req;
    endfunction

endpackage

// File: rtl/seq_shifter.sv
// ============================================================================
// seq_shifter
// ----------------------------------------------------------------------------
// Holds the latched pattern and walks a bit index from the last active bit
// down to bit 0. The bit selected by that index is presented as cur_bit, so
// the pattern goes out MSB-of-field first.
//
// The pattern itself never moves. Only the index changes. A repetition is
// therefore just a reload of the index from the latched last-bit position.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset; clears pattern and index
//   load      in   capture data and last_idx, and set the index to last_idx
//   reload    in   set the index back to the latched last_idx
//   step      in   move to the next lower bit (ignored at index 0)
//   data      in   WIDTH  pattern to capture on load
//   last_idx  in   LEN_W  index of the first bit sent (effective length - 1)
//   cur_bit   out  pattern bit currently selected
//   last_bit  out  index is 0: the bit on cur_bit ends this repetition
//
// Configuration macros: none.
// ============================================================================
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             step,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] last_idx,
    output logic             cur_bit,
    output logic             last_bit
);

    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] last_idx_q;
    logic [LEN_W-1:0] bitcnt;

    // Pattern and reload value are captured only on load. Later changes to
    // the parent's inputs cannot disturb a transfer that is in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern    <= '0;
            last_idx_q <= '0;
        end else if (load) begin
            pattern    <= data;
            last_idx_q <= last_idx;
        end
    end

    // Bit index. Load takes priority over reload, and reload over step.
    // A step at index 0 is ignored, so the index can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt <= '0;
        end else if (load) begin
            bitcnt <= last_idx;
        end else if (reload) begin
            bitcnt <= last_idx_q;
        end else if (step && bitcnt != '0) begin
            bitcnt <= bitcnt - LEN_W'(1);
        end
    end

    // Bit-select mux. The index is wider than strictly needed to address
    // WIDTH bits, so the mux is written as a compare against each position
    // rather than as a direct part-select.
    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bitcnt == LEN_W'(i)) begin
                cur_bit = pattern[i];
            end
        end
    end

    // Flags the final bit of the current repetition.
    always_comb begin
        last_bit = (bitcnt == '0);
    end

endmodule

// File: rtl/seq_generator.sv
// ============================================================================
// seq_generator
// ----------------------------------------------------------------------------
// Serial pattern transmitter. When start is seen while ready, it captures a
// parallel pattern and sends bits [len-1:0] on X, MSB first, one bit per
// clock. The pattern is sent reps+1 times back to back, with no gap between
// repetitions. A one-cycle done pulse follows the last bit, and ready
// returns on the cycle after that.
//
// X has the same meaning as the input of the 101 sequence detector, so it
// can drive that detector directly. Repeating "101" produces "101101...",
// which exercises the detector's overlapping matches.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-low reset
//   start  in   transfer request; honoured only while ready is 1
//   data   in   WIDTH  pattern; bits [len-1:0] are sent, data[len-1] first
//   len    in   LEN_W  bits per repetition; 0 or > WIDTH means WIDTH
//   reps   in   4      extra repetitions (total transmissions = reps + 1)
//   X      out  serial bit; 0 whenever valid is 0
//   valid  out  X carries a pattern (or parity) bit this cycle
//   ready  out  idle; a start on this cycle will be accepted
//   done   out  one-cycle pulse on the cycle after the last bit
//
// Configuration macro:
//   SEQGEN_PARITY_EN  when defined, every repetition is followed by one
//                     even-parity bit (the XOR of that repetition's bits),
//                     sent from the PAR state with valid = 1.
//
// Outputs are decoded only from state and registered data, so no input has
// a combinational path to an output.
// ============================================================================
module seq_generator
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  data,
    input  logic [LEN_W-1:0]  len,
    input  logic [REPS_W-1:0] reps,
    output logic              X,
    output logic              valid,
    output logic              ready,
    output logic              done
);

    seq_state_t        state;
    seq_state_t        state_next;

    logic [REPS_W-1:0] repcnt;
    logic [LEN_W-1:0]  last_idx;

    logic              load;
    logic              reload;
    logic              step;
    logic              cur_bit;
    logic              last_bit;

`ifdef SEQGEN_PARITY_EN
    logic              parity;
`endif

    // Translate the requested length into the index of the first bit sent.
    // The pattern register always holds at least one bit, so the subtraction
    // cannot go negative.
    always_comb begin
        last_idx = LEN_W'(eff_len(int'(len), WIDTH) - 1);
    end

    // Shifter control. Load happens on acceptance. Step walks through a
    // repetition. Reload starts the next repetition, either straight from the
    // last data bit or, with parity enabled, from the parity bit.
    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == SEND) && !last_bit;
`ifdef SEQGEN_PARITY_EN
        reload = (state == PAR) && (repcnt != '0);
`else
        reload = (state == SEND) && last_bit && (repcnt != '0);
`endif
    end

    seq_shifter #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .reload   (reload),
        .step     (step),
        .data     (data),
        .last_idx (last_idx),
        .cur_bit  (cur_bit),
        .last_bit (last_bit)
    );

    // Repetition counter. It is loaded with the extra-repetition count on
    // acceptance and decremented once per reload. Because reload only fires
    // while it is nonzero, it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repcnt <= '0;
        end else if (load) begin
            repcnt <= reps;
        end else if (reload) begin
            repcnt <= repcnt - REPS_W'(1);
        end
    end

`ifdef SEQGEN_PARITY_EN
    // Running even parity over the bits of the current repetition. It is
    // cleared on acceptance and again after each parity bit has been sent,
    // so every repetition gets its own parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= 1'b0;
        end else if (state == SEND) begin
            parity <= parity ^ cur_bit;
        end else if (state == PAR) begin
            parity <= 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start outside IDLE is simply not looked at, so a
    // request made during a transfer is dropped rather than queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_bit) begin
`ifdef SEQGEN_PARITY_EN
                    state_next = PAR;
`else
                    state_next = (repcnt != '0) ? SEND : DONE;
`endif
                end
            end
`ifdef SEQGEN_PARITY_EN
            PAR: begin
                state_next = (repcnt != '0) ? SEND : DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore output decode. X is forced low whenever valid is low, so the
    // downstream detector sees a clean 0 between transfers.
    always_comb begin
        X     = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SEND: begin
                valid = 1'b1;
                X     = cur_bit;
            end
`ifdef SEQGEN_PARITY_EN
            PAR: begin
                valid = 1'b1;
                X     = parity;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                X     = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_generator.sv
// ============================================================================
// tb_seq_generator
// ----------------------------------------------------------------------------
// Self-checking bench for seq_generator (WIDTH = 8).
//
// A behavioural model turns each accepted request into the full list of
// per-cycle outputs it should produce: the bits, any parity bits, and the
// done cycle. One compare process checks the DUT against that list on every
// cycle. Directed transfers also check the captured bit stream, the bit
// count, the done latency, the ready return, and the number of "101"
// matches, all against hand-written literals.
// ============================================================================
`timescale 1ns/1ps
module tb_seq_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] reps;
    logic       X;
    logic       valid;
    logic       ready;
    logic       done;

    int checkCount;
    int passCount;

    // Expected {X, valid, ready, done} for each upcoming cycle of a transfer.
    logic [3:0] expQ[$];

    seq_generator #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .len   (len),
        .reps  (reps),
        .X     (X),
        .valid (valid),
        .ready (ready),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single place where comparisons are counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: build the whole output sequence of one transfer from the
    // request fields.
    task automatic buildStream(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        int  eff;
        logic p;
        eff = (l == 0 || l > 8) ? 8 : int'(l);
        for (int rep = 0; rep <= int'(r); rep++) begin
            p = 1'b0;
            for (int i = eff - 1; i >= 0; i--) begin
                p = p ^ d[i];
                expQ.push_back({d[i], 1'b1, 1'b0, 1'b0});
            end
`ifdef SEQGEN_PARITY_EN
            expQ.push_back({p, 1'b1, 1'b0, 1'b0});
`endif
        end
        expQ.push_back(4'b0001);
    endtask

    // Model sequencing. The model is idle exactly when nothing is pending,
    // and only then is a start taken. Reset drops anything pending at once.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            expQ.delete();
        end else if (expQ.size() == 0) begin
            if (start) buildStream(data, len, reps);
        end else begin
            void'(expQ.pop_front());
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] exp;
        exp = (expQ.size() == 0) ? 4'b0010 : expQ[0];
        checkOutput("cycle_outputs", {28'd0, X, valid, ready, done}, {28'd0, exp});
    end

    // Counts overlapping "101" matches in the low n captured bits, as the
    // downstream detector would report them.
    function automatic int count101(input logic [31:0] bits, input int n);
        int c;
        c = 0;
        for (int i = 0; i + 2 < n; i++) begin
            if (bits[i+2] && !bits[i+1] && bits[i]) c++;
        end
        return c;
    endfunction

    // Presents a request in the current (idle) cycle and holds it for exactly
    // one accept edge. It then scrambles the request fields to show they are
    // not re-sampled.
    task automatic applyStimulus(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        data  = d;
        len   = l;
        reps  = r;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        data  = ~d;
        len   = l + 4'd1;
        reps  = r + 4'd1;
    endtask

    // Runs from the cycle after acceptance. It captures the bits, waits
    // (bounded) for done, and checks the literal expectations, including
    // ready on the cycle after done.
    task automatic captureTxn(input string name, input logic [31:0] expBits, input int expN, input int exp101);
        logic [31:0] bits;
        int n;
        int doneCyc;
        bits    = '0;
        n       = 0;
        doneCyc = -1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (valid) begin
                bits = {bits[30:0], X};
                n++;
            end
            if (done) begin
                doneCyc = c;
                break;
            end
        end
        if (doneCyc < 0) begin
            checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
        end
        checkOutput({name, "_bits"}, bits, expBits);
        checkOutput({name, "_nbits"}, n, expN);
        checkOutput({name, "_done_cycle"}, doneCyc, expN + 1);
        checkOutput({name, "_matches101"}, count101(bits, n), exp101);
        @(negedge clk);
        checkOutput({name, "_ready_back"}, {31'd0, ready}, 32'd1);
    endtask

    // Complete directed transfer starting from an idle cycle. It leaves the
    // bench at the same phase it started from.
    task automatic runTxn(input string name, input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                          input logic [31:0] expBits, input int expN, input int exp101);
        applyStimulus(d, l, r);
        captureTxn(name, expBits, expN, exp101);
        @(posedge clk);
        #2;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst   = 1'b0;
        start = 1'b0;
        data  = '0;
        len   = '0;
        reps  = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_state", {28'd0, X, valid, ready, done}, 32'h2);
        @(posedge clk);
        #2;

`ifndef SEQGEN_PARITY_EN
        runTxn("p101_once",  8'h05, 4'd3,  4'd0, 32'h5,   3, 1);
        runTxn("p101_x3",    8'h05, 4'd3,  4'd2, 32'h16D, 9, 3);
        runTxn("len0_a5",    8'hA5, 4'd0,  4'd0, 32'hA5,  8, 2);
        runTxn("len12_3c",   8'h3C, 4'd12, 4'd0, 32'h3C,  8, 0);
        runTxn("len1_x4",    8'h01, 4'd1,  4'd3, 32'hF,   4, 0);
        runTxn("len2_x2",    8'hFE, 4'd2,  4'd1, 32'hA,   4, 1);

        // A start and new data during SEND must not disturb the stream. The
        // held start is taken only once ready returns.
        applyStimulus(8'h05, 4'd3, 4'd2);
        fork
            captureTxn("restart_first", 32'h16D, 9, 3);
            begin
                repeat (2) @(posedge clk);
                #2;
                start = 1'b1;
                data  = 8'hFF;
                len   = 4'd3;
                reps  = 4'd0;
            end
        join
        @(posedge clk);
        #2;
        start = 1'b0;
        captureTxn("restart_second", 32'h7, 3, 0);
        @(posedge clk);
        #2;
`else
        runTxn("par_p101_x2",  8'h05, 4'd3, 4'd1, 32'hAA, 8, 3);
        runTxn("par_p101_once", 8'h05, 4'd3, 4'd0, 32'hA, 4, 1);
`endif

        // Reset in the middle of SEND (second bit of three). It forces idle
        // outputs immediately, no done follows, and the block restarts cleanly.
        applyStimulus(8'h05, 4'd3, 4'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_midsend", {28'd0, X, valid, ready, done}, 32'h2);
        repeat (3) @(negedge clk);
        checkOutput("reset_no_done", {30'd0, done, valid}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
`ifndef SEQGEN_PARITY_EN
        runTxn("after_reset", 8'h05, 4'd3, 4'd0, 32'h5, 3, 1);
`else
        runTxn("after_reset", 8'h05, 4'd3, 4'd0, 32'hA, 4, 1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop if the bench itself ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seq_generator.md
# seq_generator

- Serial pattern transmitter: captures a parallel bit pattern on a start request and shifts it out one bit per clock on `X`, MSB of the active field first, repeated a programmable number of times.
- Direction and meaning of `X` match the input of the team's 101 sequence detector, so it drives that detector directly.
- Used as the stimulus and source end of the serial-pattern path.
- Moore-style FSM with registered outputs.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request; accepted only when `ready`=1.
- `data`  input  WIDTH  pattern; bits `[len-1:0]` are sent, `data[len-1]` first.
- `len`  input  LEN_W  bits per repetition; 0 or >WIDTH means WIDTH.
- `reps`  input  4  extra repetitions; total transmissions = `reps`+1.
- `X`  output  1  serial bit; 0 whenever `valid`=0.
- `valid`  output  1  `X` carries a pattern bit this cycle.
- `ready`  output  1  idle, start will be accepted.
- `done`  output  1  one-cycle pulse after the last bit.

## Operation
- States: `IDLE`, `SEND`, `PAR` (macro only), `DONE`.
- `IDLE`: `ready`=1. On `start`=1:
  - latch `data`, effective `len`, and `reps` into internal registers;
  - load the bit counter with len−1 and the repetition counter with `reps`;
  - go to `SEND`.
- `SEND`: drive `X`=latched `data[bitcnt]`, `valid`=1, `ready`=0.
  - bitcnt>0: decrement.
  - bitcnt=0 with macro: go to `PAR`.
  - bitcnt=0 without macro, repcnt>0: decrement repcnt, reload bitcnt=len−1, stay in `SEND`.
  - bitcnt=0 without macro, repcnt=0: go to `DONE`.
- Repetitions are back-to-back with no idle bit, so pattern 101 repeated gives 101101… and exercises overlapping detection downstream.
- `DONE`: `done`=1, `valid`=0, `X`=0, `ready`=0; next state `IDLE`.
- `start` outside `IDLE` is ignored, not queued.
- `data`, `len`, and `reps` are sampled only at acceptance; later changes have no effect.
- Counters never underflow: decrement only when nonzero.
- Reset (any state, any cycle) forces `IDLE` and clears all counters and latched data.

## Timing
- Reset values: `X`=0, `valid`=0, `ready`=1, `done`=0, state `IDLE`.
- All outputs are registered; no combinational path from inputs to outputs.
- `start` accepted at edge k → first bit on `X` with `valid`=1 in cycle k+1.
- Without macro: bits occupy cycles k+1 … k+N, where N=len·(reps+1).
- `done` is high in cycle k+N+1. `ready` returns in cycle k+N+2, so the earliest next accept is at edge k+N+2.
- `start` held high continuously produces one transaction per N+2 cycles.

## Configuration
- `SEQGEN_PARITY_EN` defined:
  - after each repetition's last data bit, state `PAR` emits one even-parity bit (XOR of the len sent bits) with `valid`=1;
  - from `PAR`: repcnt>0 → decrement, reload bitcnt, back to `SEND`; else → `DONE`;
  - N=(len+1)·(reps+1).
- Undefined: `PAR` state and parity logic are absent; behaviour as above.

## Structure
- Shared package `seq_pkg`:
  - state typedef `seq_state_t` (2-bit: IDLE=00, SEND=01, PAR=10, DONE=11);
  - `REPS_W`=4;
  - the state encoding shared with the detector's naming.
- One sub-module, `seq_shifter`: latched pattern, bit counter with reload, and bit-select mux. Interface: load, reload, step, current bit, last-bit flag. The top holds the FSM, repetition counter, and parity.

## Test plan
- data=3'b101 (WIDTH=8, data=8'h05), len=3, reps=0, start pulse → `X`/`valid` = 1,0,1 in cycles k+1..k+3; `done` in k+4; `ready` in k+5. Driving the 101 detector gives exactly one Z pulse.
- Same pattern, reps=2 → `X`=101101101 over 9 cycles; the detector gives 3 Z pulses; `done` in k+10.
- len=0, data=8'hA5 → 8 bits 1,0,1,0,0,1,0,1; `done` in k+9.
- `start` re-asserted and `data` changed during `SEND` → output stream unchanged; a new transaction is accepted only after `ready`=1.
- `rst` asserted in mid-`SEND` (bit 2 of 3) → in the same cycle `X`=0, `valid`=0, `ready`=1, no `done` pulse; a fresh start works normally afterward.
- With `SEQGEN_PARITY_EN`: data=101, len=3, reps=1 → `X`=1010 1010; `done` in k+9.
